// File: rtl/pc_unit.sv
// Program-counter stage: registers the next PC, tracks run/halt/trap state,
// flags misaligned branch/jump targets and counts retired instructions.
module pc_unit #(
   parameter logic [31:0] RESET_PC         = 32'h0000_0000,
   parameter bit          TRAP_ON_MISALIGN = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        NextPCSrc,
   input  logic [31:0] ALURes,
   input  logic        Stall,
   input  logic        Halt,
   output logic [31:0] PC,
   output logic [31:0] PCInc,
   output logic        Running,
   output logic        Trap,
   output logic [31:0] TrapPC,
   output logic [31:0] InstrCount
);

   typedef enum logic [1:0] {
      ST_RUN  = 2'b00,
      ST_HALT = 2'b01,
      ST_TRAP = 2'b10
   } state_t;

   // Bit 0 is always dropped (JALR rule); bit 1 is dropped only when misalignment does not trap.
   localparam logic [31:0] ALIGN_MASK = TRAP_ON_MISALIGN ? 32'hFFFF_FFFE : 32'hFFFF_FFFC;

   state_t      state_r;
   state_t      state_nxt_s;
   logic [31:0] pc_r;
   logic [31:0] pc_nxt_s;
   logic [31:0] pc_inc_s;
   logic [31:0] trap_pc_r;
   logic [31:0] trap_pc_nxt_s;
   logic [31:0] count_r;
   logic [31:0] count_nxt_s;
   logic        running_r;
   logic        trap_r;
   logic [31:0] target_s;
   logic        misaligned_s;

   assign pc_inc_s     = pc_r + 32'd4;
   assign target_s     = ALURes & ALIGN_MASK;
   assign misaligned_s = ALURes[1];

   // Next-state, next-PC and retire-count decision
   always_comb begin
      state_nxt_s   = state_r;
      pc_nxt_s      = pc_r;
      trap_pc_nxt_s = trap_pc_r;
      count_nxt_s   = count_r;
      case (state_r)
         ST_RUN: begin
            if (Stall) begin
               state_nxt_s = ST_RUN;
            end else if (Halt) begin
               count_nxt_s = count_r + 32'd1;
               state_nxt_s = ST_HALT;
            end else if (NextPCSrc && misaligned_s && TRAP_ON_MISALIGN) begin
               // The faulting instruction does not retire.
               trap_pc_nxt_s = pc_r;
               state_nxt_s   = ST_TRAP;
            end else if (NextPCSrc) begin
               pc_nxt_s    = target_s;
               count_nxt_s = count_r + 32'd1;
            end else begin
               pc_nxt_s    = pc_inc_s;
               count_nxt_s = count_r + 32'd1;
            end
         end
         ST_HALT: begin
            state_nxt_s = ST_HALT;
         end
         ST_TRAP: begin
            state_nxt_s = ST_TRAP;
         end
         default: begin
            state_nxt_s   = ST_TRAP;
            trap_pc_nxt_s = pc_r;
         end
      endcase
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= ST_RUN;
         pc_r      <= RESET_PC;
         trap_pc_r <= 32'h0000_0000;
         count_r   <= 32'h0000_0000;
         running_r <= 1'b1;
         trap_r    <= 1'b0;
      end else begin
         state_r   <= state_nxt_s;
         pc_r      <= pc_nxt_s;
         trap_pc_r <= trap_pc_nxt_s;
         count_r   <= count_nxt_s;
         running_r <= (state_nxt_s == ST_RUN);
         trap_r    <= (state_nxt_s == ST_TRAP);
      end
   end

   assign PC         = pc_r;
   assign PCInc      = pc_inc_s;
   assign Running    = running_r;
   assign Trap       = trap_r;
   assign TrapPC     = trap_pc_r;
   assign InstrCount = count_r;

endmodule
